// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor.
// One BCD digit per clock, least significant first, with +6 decimal correction.
// Subtraction adds the nines' complement of B with an inverted borrow-in, so a
// negative difference comes back in ten's complement with cout=0.
// Operands holding a digit above 9 flag err and force a zero result.
module bcd_serial_adder #(
  parameter int DIGITS = 4,
  parameter int CNTW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [4*DIGITS-1:0] a_r;
  logic [4*DIGITS-1:0] b_r;
  logic                sub_r;
  logic                carry_r;
  logic                err_int_r;
  logic [CNTW-1:0]     cnt_r;

  logic [3:0]          a_dig_s;
  logic [3:0]          b_dig_s;
  logic [4:0]          res_s;
  logic                last_s;

  // One decimal digit step: {carry_out, digit}; B is nines'-complemented when subtracting.
  function automatic logic [4:0] bcd_digit(input logic [3:0] ad, input logic [3:0] bdig,
                                           input logic sub_m, input logic c_in);
    logic [3:0] bd;
    logic [4:0] t;
    logic [4:0] r;
    bd = sub_m ? (4'd9 - bdig) : bdig;
    t  = {1'b0, ad} + {1'b0, bd} + {4'd0, c_in};
    if (t > 5'd9) begin
      r = {1'b1, t[3:0] + 4'd6};
    end else begin
      r = {1'b0, t[3:0]};
    end
    return r;
  endfunction

  // True when any packed digit of the operand lies outside 0..9.
  function automatic logic bad_digits(input logic [4*DIGITS-1:0] v);
    logic f;
    f = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      f = f | (v[4*i +: 4] > 4'd9);
    end
    return f;
  endfunction

  // Select the operand digits addressed by the digit counter (AND-OR mux).
  always_comb begin
    a_dig_s = 4'd0;
    b_dig_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      a_dig_s = a_dig_s | (a_r[4*i +: 4] & {4{cnt_r == CNTW'(i)}});
      b_dig_s = b_dig_s | (b_r[4*i +: 4] & {4{cnt_r == CNTW'(i)}});
    end
    res_s  = bcd_digit(a_dig_s, b_dig_s, sub_r, carry_r);
    last_s = (cnt_r == CNTW'(DIGITS - 1));
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      carry_r   <= 1'b0;
      err_int_r <= 1'b0;
      cnt_r     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r       <= a;
            b_r       <= b;
            sub_r     <= sub;
            cnt_r     <= '0;
            carry_r   <= sub ? ~cin : cin;
            err_int_r <= bad_digits(a) | bad_digits(b);
            err       <= 1'b0;
            cout      <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ADD;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_r == CNTW'(i)) begin
              sum[4*i +: 4] <= res_s[3:0];
            end
          end
          carry_r <= res_s[4];
          cnt_r   <= cnt_r + CNTW'(1);
          if (last_s) begin
            // Final digit: publish the result with the completion pulse.
            done    <= 1'b1;
            err     <= err_int_r;
            state_r <= DONE;
            if (err_int_r) begin
              sum  <= '0;
              cout <= 1'b0;
            end else begin
              cout <= res_s[4];
            end
          end else begin
            state_r <= ADD;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: vector table on a 4-digit instance plus
// hand sequences for ignored start, back-to-back starts, mid-operation reset,
// and 1-digit / 8-digit instances.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, sub, cin;
  logic [15:0] a, b, sum;
  logic        cout, busy, done, err;

  logic        rst_aux_n, start_aux, sub_aux, cin_aux;
  logic [3:0]  a1, b1, sum1;
  logic        cout1, busy1, done1, err1;
  logic [31:0] a8, b8, sum8;
  logic        cout8, busy8, done8, err8;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        e;
  } vec_t;

  vec_t vt[11];

  bcd_serial_adder #(.DIGITS(4), .CNTW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1), .CNTW(3)) dut1 (
    .clk(clk), .rst_n(rst_aux_n), .start(start_aux), .sub(sub_aux), .cin(cin_aux),
    .a(a1), .b(b1), .sum(sum1), .cout(cout1), .busy(busy1), .done(done1), .err(err1)
  );

  bcd_serial_adder #(.DIGITS(8), .CNTW(3)) dut8 (
    .clk(clk), .rst_n(rst_aux_n), .start(start_aux), .sub(sub_aux), .cin(cin_aux),
    .a(a8), .b(b8), .sum(sum8), .cout(cout8), .busy(busy8), .done(done8), .err(err8)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one operation on the 4-digit instance and check timing and result.
  task automatic run_vec(input string nm, input vec_t v);
    int          lat;
    int          busy_cnt;
    logic [15:0] s_got;
    logic        c_got, e_got;
    lat = 0; busy_cnt = 0; s_got = '0; c_got = 1'b0; e_got = 1'b0;
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; sub = ~v.sub; cin = ~v.cin;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (busy) busy_cnt++;
      tick();
      if (done) begin
        lat = k; s_got = sum; c_got = cout; e_got = err;
        if (busy) busy_cnt++;
      end
    end
    check({nm, " latency"}, lat, DIGITS);
    check({nm, " sum"}, s_got, v.s);
    check({nm, " cout"}, c_got, v.c);
    check({nm, " err"}, e_got, v.e);
    check({nm, " busy cycles"}, busy_cnt, DIGITS + 1);
    tick();
    check({nm, " done pulse width"}, done, 1'b0);
    check({nm, " idle busy"}, busy, 1'b0);
    tick();
    check({nm, " sum hold"}, sum, v.s);
  endtask

  // Run one operation on both auxiliary instances in parallel.
  task automatic run_aux(input string nm, input logic [3:0] xa1, input logic [3:0] xb1,
                         input logic [31:0] xa8, input logic [31:0] xb8,
                         input logic xs, input logic xc,
                         input logic [3:0] es1, input logic ec1,
                         input logic [31:0] es8, input logic ec8);
    int          lat1, lat8;
    logic [3:0]  s1;
    logic [31:0] s8;
    logic        c1, c8;
    lat1 = 0; lat8 = 0; s1 = '0; s8 = '0; c1 = 1'b0; c8 = 1'b0;
    a1 = xa1; b1 = xb1; a8 = xa8; b8 = xb8; sub_aux = xs; cin_aux = xc; start_aux = 1'b1;
    tick();
    start_aux = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done1 && lat1 == 0) begin lat1 = k; s1 = sum1; c1 = cout1; end
      if (done8 && lat8 == 0) begin lat8 = k; s8 = sum8; c8 = cout8; end
    end
    check({nm, " d1 latency"}, lat1, 1);
    check({nm, " d1 sum"}, s1, es1);
    check({nm, " d1 cout"}, c1, ec1);
    check({nm, " d8 latency"}, lat8, 8);
    check({nm, " d8 sum"}, s8, es8);
    check({nm, " d8 cout"}, c8, ec8);
  endtask

  int          d_first, d_second, n_done;
  logic [15:0] s_cap;
  logic        c_cap;

  initial begin
    //        a        b        sub   cin   sum      cout  err
    vt[0]  = '{16'h1234, 16'h8766, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h0999, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0};
    vt[2]  = '{16'h0100, 16'h0001, 1'b1, 1'b0, 16'h0099, 1'b1, 1'b0};
    vt[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0};
    vt[4]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
    vt[5]  = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[6]  = '{16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[7]  = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{16'h5000, 16'h5000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[9]  = '{16'h4321, 16'h1234, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
    vt[10] = '{16'h0000, 16'h00F0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    rst_aux_n = 1'b0; start_aux = 1'b0; sub_aux = 1'b0; cin_aux = 1'b0;
    a1 = '0; b1 = '0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("reset sum", sum, 16'h0000);
    check("reset flags", {cout, busy, done, err}, 4'b0000);
    rst_n = 1'b1; rst_aux_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_vec($sformatf("v%0d", i), vt[i]);
    end

    // Start pulsed again two cycles into an operation is ignored.
    a = 16'h1234; b = 16'h8766; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    n_done = 0; s_cap = '1; c_cap = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin n_done++; s_cap = sum; c_cap = cout; end
      tick();
    end
    check("ignored start done count", n_done, 1);
    check("ignored start sum", s_cap, 16'h0000);
    check("ignored start cout", c_cap, 1'b1);
    check("ignored start idle", busy, 1'b0);

    // Start held high: operations repeat every DIGITS+2 cycles.
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    d_first = 0; d_second = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        if (d_first == 0) d_first = k;
        else if (d_second == 0) d_second = k;
      end
    end
    start = 1'b0;
    check("back-to-back period", d_second - d_first, DIGITS + 2);
    check("back-to-back sum", sum, 16'h0002);
    for (int k = 0; k < 8; k++) tick();
    check("back-to-back idle", busy, 1'b0);

    // Reset while digit 2 is being processed.
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("partial sum before reset", sum, 16'h0033);
    rst_n = 1'b0;
    #1;
    check("mid-op reset sum", sum, 16'h0000);
    check("mid-op reset flags", {cout, busy, done, err}, 4'b0000);
    n_done = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) n_done++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done) n_done++;
    end
    check("mid-op reset no done", n_done, 0);
    check("mid-op reset idle", busy, 1'b0);
    run_vec("after reset", '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});

    // 1-digit and 8-digit instances: reset mid-operation, then operate.
    a1 = 4'h1; b1 = 4'h2; a8 = 32'h11111111; b8 = 32'h22222222;
    sub_aux = 1'b0; cin_aux = 1'b0; start_aux = 1'b1;
    tick();
    start_aux = 1'b0;
    tick();
    check("d1 done after one digit", {done1, sum1}, {1'b1, 4'h3});
    check("d8 partial sum", sum8, 32'h00000003);
    rst_aux_n = 1'b0;
    #1;
    check("aux reset d1", {sum1, cout1, busy1, done1, err1}, 8'h00);
    check("aux reset d8", {sum8, cout8, busy8, done8, err8}, 36'h0);
    tick();
    rst_aux_n = 1'b1;
    tick();
    run_aux("aux add", 4'h9, 4'h9, 32'h99999999, 32'h00000001, 1'b0, 1'b0,
            4'h8, 1'b1, 32'h00000000, 1'b1);
    run_aux("aux sub", 4'h3, 4'h5, 32'h00000005, 32'h00000007, 1'b1, 1'b0,
            4'h8, 1'b0, 32'h99999998, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
